fifo_burst_reader: RTL and testbench
====================================

Name: fifo_burst_reader

Overview:
- Consumer at the read end of the team's synchronous FIFO: issues rd_en, absorbs the FIFO's 1-cycle registered read latency, and presents words as a valid/ready stream.
- Groups output words into packets of BURST beats, with m_last on the final beat.
- A partial packet is closed by a timeout flush when the FIFO runs dry.
- Sits between the FIFO's read port and any downstream valid/ready sink.

Parameters:
- WIDTH, 8: data word width; must match the FIFO WIDTH.
- BURST, 4: beats per full packet; must be at least 2.
- TIMEOUT, 16: idle cycles before a partial packet is flushed; must be at least 1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- fifo_rd_en  out  1  read strobe to the FIFO.
- fifo_dout  in  WIDTH  FIFO read data; valid the cycle after an accepted read.
- fifo_empty  in  1  FIFO empty flag.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  WIDTH  output word.
- m_last  out  1  final beat of a packet.
- pkt_cnt  out  16  count of completed packets; wraps modulo 2^16.

Behaviour:
- Reset: synchronous, active-high, on clk posedge. Clears buffer, inflight, beat_cnt, timer, pkt_cnt and state (to IDLE).
  - Buffered and in-flight words are discarded.
  - While rst is high: fifo_rd_en=0, m_valid=0, m_last=0, m_data=0.
- Internal 3-entry in-order skid buffer, occupancy buf_cnt (0..3). inflight is a 1-bit register equal to the previous cycle's fifo_rd_en.
- Read rule: fifo_rd_en = !rst && !fifo_empty && (buf_cnt + inflight) < 3.
  - Combinational on registered state only; no path from m_ready.
  - When inflight=1, fifo_dout is written to the buffer tail that cycle.
- Throughput: with m_ready held high and the FIFO non-empty, sustains 1 word/cycle.
- m_data is always the buffer head. It must stay stable while m_valid && !m_ready.
- Handshake = m_valid && m_ready; pops the head.
  - Simultaneous push (inflight) and pop leaves buf_cnt unchanged.
- beat_cnt (0..BURST-1):
  - +1 on a handshake without m_last.
  - Reset to 0 on a handshake with m_last; pkt_cnt increments on that same handshake.
- m_last = m_valid && (beat_cnt == BURST-1 || state == FLUSH).
- m_valid = buf_cnt>=2 || (buf_cnt==1 && (inflight || !fifo_empty || beat_cnt==BURST-1 || state==FLUSH)).
  - A lone buffered tail word with nothing behind it is held back, not presented.
  - By construction m_valid never drops before a handshake. Verification asserts this: once m_valid is high, it and m_data/m_last stay stable until the handshake.
- State machine (registered):
  - IDLE: buf_cnt==0 && !inflight. Goes to STREAM when any word is buffered or in flight.
  - STREAM: normal presentation.
    - To HOLD when buf_cnt==1, !inflight, fifo_empty, beat_cnt!=BURST-1.
    - To IDLE when empty.
  - HOLD: m_valid=0; timer increments each cycle.
    - New data arriving (fifo_empty falls) returns to STREAM, timer cleared; the word goes out with m_last=0.
    - Timer reaching TIMEOUT-1 goes to FLUSH.
  - FLUSH: tail word presented with m_valid=1, m_last=1 until the handshake, even if the FIFO refills meanwhile. After the handshake, beat_cnt=0, timer=0, then IDLE or STREAM.
- Packet boundaries:
  - A packet never exceeds BURST beats.
  - A flushed packet has 1..BURST-1 beats.
  - A lone word with beat_cnt==0 can also be flushed, giving a 1-beat packet.
- Overflow/underflow:
  - fifo_rd_en is never asserted while fifo_empty=1.
  - The buffer never exceeds 3 entries.
  - Both are checked by bench assertions.

Test Plan:
- Reset then push 8 words 0x10..0x17, m_ready=1 → 8 consecutive beats 0x10..0x17; m_last on 0x13 and 0x17; pkt_cnt=2; no HOLD.
- Push 0x01..0x06, m_ready=1 → 0x01..0x04 sent as a full packet. 0x05 is sent with m_last=0. 0x06 is held in HOLD with m_valid=0 for 16 cycles, then flushed with m_last=1; pkt_cnt=2.
- Push 0xA0..0xA3 with m_ready=0 for 10 cycles → buf_cnt saturates at 3 and fifo_rd_en drops; m_valid=1 with m_data=0xA0 stable throughout. Raise m_ready → 0xA0..0xA3 in order, m_last on 0xA3.
- Push 0x31 (beat 0) and let it HOLD for 5 cycles, then push 0x32 → 0x31 presented with m_last=0 when 0x32 becomes available; timer restarts.
- Toggle m_ready 1010… during a 12-word stream → no loss or duplication; m_last on every 4th beat; m_valid never drops without a handshake.
- Assert rst for 1 cycle mid-packet with 2 words buffered → the cycle after: m_valid=0, pkt_cnt=0, beat_cnt=0. A subsequent 4-word burst is delivered as a fresh packet.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// Read-side consumer for the synchronous FIFO: absorbs the 1-cycle read latency
// in a 3-entry skid buffer and emits BURST-beat packets with a timeout flush.
module fifo_burst_reader #(
  parameter int WIDTH   = 8,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [15:0]      pkt_cnt
);

  localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, STREAM, HOLD, FLUSH} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  buf_q [3];
  logic [WIDTH-1:0]  buf_d [3];
  logic [1:0]        buf_cnt_q, buf_cnt_d;
  logic              inflight_q;
  logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [15:0]       pkt_cnt_q, pkt_cnt_d;
  logic              at_last_beat;
  logic              hs;

  always_comb begin
    at_last_beat = (beat_cnt_q == LAST_BEAT);
    fifo_rd_en   = !rst && !fifo_empty &&
                   (({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < 3'd3);
    // A lone tail word is only shown once something follows it, the packet
    // is complete, or the timeout has forced a flush.
    m_valid      = !rst && ((buf_cnt_q >= 2'd2) ||
                   (buf_cnt_q == 2'd1 && (inflight_q || !fifo_empty ||
                                          at_last_beat || state_q == FLUSH)));
    m_last       = m_valid && (at_last_beat || state_q == FLUSH);
    m_data       = rst ? '0 : buf_q[0];
    pkt_cnt      = pkt_cnt_q;
    hs           = m_valid && m_ready;

    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    if (hs) begin
      buf_d[0]  = buf_q[1];
      buf_d[1]  = buf_q[2];
      buf_cnt_d = buf_cnt_q - 2'd1;
    end
    if (inflight_q) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (buf_cnt_d == 2'(i)) buf_d[i] = fifo_dout;
      end
      buf_cnt_d = buf_cnt_d + 2'd1;
    end

    beat_cnt_d = beat_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (hs) begin
      if (m_last) begin
        beat_cnt_d = '0;
        pkt_cnt_d  = pkt_cnt_q + 16'd1;
      end else begin
        beat_cnt_d = beat_cnt_q + BW'(1);
      end
    end

    state_d = state_q;
    timer_d = '0;
    case (state_q)
      IDLE:   if (buf_cnt_d != 2'd0 || fifo_rd_en) state_d = STREAM;
      STREAM: begin
        if (buf_cnt_q == 2'd1 && !inflight_q && fifo_empty && !at_last_beat)
          state_d = HOLD;
        else if (buf_cnt_d == 2'd0 && !fifo_rd_en)
          state_d = IDLE;
      end
      HOLD: begin
        if (!fifo_empty)          state_d = STREAM;
        else if (timer_q == TMAX) state_d = FLUSH;
        else                      timer_d = timer_q + TW'(1);
      end
      FLUSH:  if (hs) state_d = (buf_cnt_d != 2'd0 || fifo_rd_en) ? STREAM : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      buf_cnt_q  <= '0;
      inflight_q <= 1'b0;
      beat_cnt_q <= '0;
      timer_q    <= '0;
      pkt_cnt_q  <= '0;
      for (int unsigned i = 0; i < 3; i++) buf_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      buf_cnt_q  <= buf_cnt_d;
      inflight_q <= fifo_rd_en;
      beat_cnt_q <= beat_cnt_d;
      timer_q    <= timer_d;
      pkt_cnt_q  <= pkt_cnt_d;
      for (int unsigned i = 0; i < 3; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: FIFO model, expected-beat scoreboard, directed
// sequences from a vector table, and a randomized ready stream.
module tb_fifo_burst_reader;

  localparam int WIDTH   = 8;
  localparam int BURST   = 4;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_empty;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_last;
  logic [15:0]      pkt_cnt;

  fifo_burst_reader #(.WIDTH(WIDTH), .BURST(BURST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] din;
    logic             last;
  } vec_t;

  vec_t       vecs [39];
  vec_t       exp_q [$];
  int         hs_t [$];
  int         vec_cnt = 0;
  int         miss = 0;
  int         cyc = 0;
  int         outstanding = 0;

  logic [WIDTH-1:0] mem [1024];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vec_cnt++;
    if (act !== req) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  logic             prev_valid = 1'b0, prev_ready = 1'b0, prev_rst = 1'b1, prev_last = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    vec_t e;
    logic hsn;
    hsn = m_valid && m_ready;
    if (rst) begin
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_last", 32'(m_last), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      outstanding = 0;
    end else begin
      chk("rd_when_empty", 32'(fifo_rd_en && fifo_empty), 32'd0);
      chk("buf_overflow", 32'(outstanding <= 3), 32'd1);
      if (prev_valid && !prev_ready && !prev_rst) begin
        chk("stable_valid", 32'(m_valid), 32'd1);
        chk("stable_data", 32'(m_data), 32'(prev_data));
        chk("stable_last", 32'(m_last), 32'(prev_last));
      end
      if (hsn) begin
        chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(m_data), 32'(e.din));
          chk("beat_last", 32'(m_last), 32'(e.last));
        end
        hs_t.push_back(cyc);
      end
      outstanding = outstanding + int'(fifo_rd_en) - int'(hsn);
    end
    prev_valid = m_valid;
    prev_ready = m_ready;
    prev_rst   = rst;
    prev_data  = m_data;
    prev_last  = m_last;
  end

  task automatic push(input logic [WIDTH-1:0] d, input logic last);
    vec_t e;
    mem[wr_ptr] = d;
    wr_ptr++;
    e.din  = d;
    e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic load(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) push(vecs[i].din, vecs[i].last);
  endtask

  // mode 0: ready held high, 1: ready toggles each cycle, 2: random ready
  task automatic drain(input int mode, input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(posedge clk); #1;
      n++;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    hs_t.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vecs[i] = '{8'(8'h10 + i), (i % 4 == 3)};
    vecs[8]  = '{8'h01, 1'b0}; vecs[9]  = '{8'h02, 1'b0};
    vecs[10] = '{8'h03, 1'b0}; vecs[11] = '{8'h04, 1'b1};
    vecs[12] = '{8'h05, 1'b0}; vecs[13] = '{8'h06, 1'b1};
    vecs[14] = '{8'hA0, 1'b0}; vecs[15] = '{8'hA1, 1'b0};
    vecs[16] = '{8'hA2, 1'b0}; vecs[17] = '{8'hA3, 1'b1};
    vecs[18] = '{8'h31, 1'b0}; vecs[19] = '{8'h32, 1'b1};
    for (int i = 0; i < 12; i++) vecs[20 + i] = '{8'(8'hC0 + i), (i % 4 == 3)};
    vecs[32] = '{8'h50, 1'b0}; vecs[33] = '{8'h51, 1'b0};
    vecs[34] = '{8'h52, 1'b0};
    vecs[35] = '{8'h60, 1'b0}; vecs[36] = '{8'h61, 1'b0};
    vecs[37] = '{8'h62, 1'b0}; vecs[38] = '{8'h63, 1'b1};

    rst = 1'b1;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("reset_valid", 32'(m_valid), 32'd0);

    // Full-rate stream of two packets
    @(posedge clk); #1;
    hs_t.delete();
    load(0, 7);
    drain(0, 100);
    chk("t1_consecutive", 32'(hs_t[7] - hs_t[0]), 32'd7);
    chk("t1_pkt_cnt", 32'(pkt_cnt), 32'd2);

    // Partial packet closed by timeout
    hs_t.delete();
    load(8, 13);
    drain(0, 100);
    chk("t2_flush_gap", 32'(hs_t[5] - hs_t[4]), 32'(TIMEOUT + 2));
    chk("t2_pkt_cnt", 32'(pkt_cnt), 32'd4);

    // Backpressure saturates the buffer
    m_ready = 1'b0;
    load(14, 17);
    repeat (3) @(negedge clk);
    repeat (7) begin
      @(negedge clk);
      chk("t3_valid", 32'(m_valid), 32'd1);
      chk("t3_data", 32'(m_data), 32'h0A0);
    end
    chk("t3_rd_en_off", 32'(fifo_rd_en), 32'd0);
    chk("t3_fifo_left", 32'(fifo_empty), 32'd0);
    @(posedge clk); #1;
    drain(0, 100);
    chk("t3_pkt_cnt", 32'(pkt_cnt), 32'd5);

    // Held word released by new data, then the follower is flushed
    do_reset();
    load(18, 18);
    repeat (8) begin
      @(negedge clk);
      chk("t4_held", 32'(m_valid), 32'd0);
    end
    @(posedge clk); #1;
    load(19, 19);
    drain(0, 100);
    chk("t4_timer_restart", 32'(hs_t[1] - hs_t[0]), 32'(TIMEOUT + 3));
    chk("t4_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Alternating ready
    load(20, 31);
    drain(1, 200);
    chk("t5_pkt_cnt", 32'(pkt_cnt), 32'd4);

    // Reset mid-packet with two words buffered
    m_ready = 1'b0;
    load(32, 34);
    repeat (6) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    load(35, 38);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_after_rst", 32'(m_valid), 32'd0);
    chk("t6_pkt_after_rst", 32'(pkt_cnt), 32'd0);
    @(posedge clk); #1;
    drain(0, 100);
    chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);

    // Random data and random ready against the scoreboard
    do_reset();
    for (int i = 0; i < 40; i++) push(8'($urandom), (i % BURST == BURST - 1));
    drain(2, 3000);
    chk("rand_pkt_cnt", 32'(pkt_cnt), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss);
    $finish;
  end

endmodule
